// File: rtl/dis7seg_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dis7seg_reader
//  Function : Samples a multiplexed 4-digit common-cathode 7-segment display
//             (active-low digit enables, active-high segments), settle-filters
//             each digit strobe, decodes the segments to BCD, assembles full
//             frames and publishes the displayed number as a 32-bit value.
//  Revision : 1.0  initial release
// ============================================================================
module dis7seg_reader #(
  parameter int SETTLE  = 16,       // stable synchronized cycles before capture (2..255)
  parameter int TIMEOUT = 1048576   // cycles without a good capture before valid drops
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en1,
  input  logic               en2,
  input  logic               en3,
  input  logic               en4,
  input  logic               seg_a,
  input  logic               seg_b,
  input  logic               seg_c,
  input  logic               seg_d,
  input  logic               seg_e,
  input  logic               seg_f,
  input  logic               seg_g,
  output logic signed [31:0] value,
  output logic               valid,
  output logic               update,
  output logic               error
);

  localparam int              c_TO_W       = $clog2(TIMEOUT);
  localparam logic [c_TO_W-1:0] c_TO_MAX   = c_TO_W'(TIMEOUT - 1);
  localparam logic [c_TO_W-1:0] c_TO_ONE   = c_TO_W'(1);
  localparam logic [7:0]      c_SETTLE_MAX = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

  // {pattern g..a, enables en4..en1}
  logic [10:0] w_in;
  logic [10:0] r_sync1;
  logic [10:0] r_sync2;
  logic [3:0]  w_en_n;
  logic [6:0]  w_pat;
  logic [3:0]  w_low;
  logic        w_single;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_en;        // latched enable set (active low, one bit clear)
  logic [6:0]  r_pat;       // latched segment pattern
  logic [7:0]  r_cnt;       // settle counter
  logic        w_load;
  logic        w_inc;
  logic        w_capture;

  logic [3:0]  w_dig;
  logic        w_dig_ok;
  logic        w_good_cap;

  logic [3:0]  r_d1, r_d2, r_d3, r_d4;
  logic [3:0]  r_mask;
  logic [3:0]  w_mask_nxt;
  logic        w_commit;
  logic [13:0] w_sum;
  logic [c_TO_W-1:0] r_to_cnt;
  logic        w_expire;

  assign w_in     = {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a, en4, en3, en2, en1};
  assign w_en_n   = r_sync2[3:0];
  assign w_pat    = r_sync2[10:4];
  assign w_low    = ~w_en_n;
  assign w_single = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);

  // Two-flop synchronizer on every display pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
    end
  end

  // Strobe FSM: next state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_single) begin
          w_state_nxt = S_SETTLE;
          w_load      = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == c_SETTLE_MAX) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HELD;
        end else if (w_en_n == r_en && w_pat == r_pat) begin
          w_inc = 1'b1;
        end else if (w_single) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HELD: begin
        // Wait for the enable set to move on so each strobe captures once
        if (w_en_n != r_en) begin
          if (w_single) begin
            w_state_nxt = S_SETTLE;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobe FSM state, latched strobe and settle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_en    <= 4'hF;
      r_pat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_en  <= w_en_n;
        r_pat <= w_pat;
        r_cnt <= '0;
      end else if (w_inc) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Segment pattern to BCD digit
  always_comb begin
    w_dig    = 4'd0;
    w_dig_ok = 1'b1;
    case (r_pat)
      7'h3F: w_dig = 4'd0;
      7'h06: w_dig = 4'd1;
      7'h5B: w_dig = 4'd2;
      7'h4F: w_dig = 4'd3;
      7'h66: w_dig = 4'd4;
      7'h6D: w_dig = 4'd5;
      7'h7D: w_dig = 4'd6;
      7'h07: w_dig = 4'd7;
      7'h7F: w_dig = 4'd8;
      7'h6F: w_dig = 4'd9;
      default: w_dig_ok = 1'b0;
    endcase
  end

  assign w_good_cap = w_capture && w_dig_ok;
  assign w_commit   = (r_mask == 4'hF);
  assign w_expire   = (r_to_cnt == c_TO_MAX) && !w_good_cap;
  assign w_sum      = 14'(r_d4) * 14'd1000 + 14'(r_d3) * 14'd100
                    + 14'(r_d2) * 14'd10   + 14'(r_d1);

  // Frame mask: commit empties it, captures set/clear the strobed digit, expiry empties it
  always_comb begin
    w_mask_nxt = w_commit ? 4'd0 : r_mask;
    if (w_capture) begin
      w_mask_nxt = w_dig_ok ? (w_mask_nxt | ~r_en) : (w_mask_nxt & r_en);
    end
    if (w_expire) begin
      w_mask_nxt = 4'd0;
    end
  end

  // Digit registers, frame commit, timeout and output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d1     <= '0;
      r_d2     <= '0;
      r_d3     <= '0;
      r_d4     <= '0;
      r_mask   <= '0;
      r_to_cnt <= '0;
      value    <= '0;
      valid    <= 1'b0;
      update   <= 1'b0;
      error    <= 1'b0;
    end else begin
      r_mask <= w_mask_nxt;
      update <= w_commit;
      error  <= w_capture && !w_dig_ok;
      if (w_good_cap) begin
        if (!r_en[0]) r_d1 <= w_dig;
        if (!r_en[1]) r_d2 <= w_dig;
        if (!r_en[2]) r_d3 <= w_dig;
        if (!r_en[3]) r_d4 <= w_dig;
      end
      // Counter saturates so an idle display stays expired until the next capture
      if (w_good_cap) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != c_TO_MAX) begin
        r_to_cnt <= r_to_cnt + c_TO_ONE;
      end
      if (w_expire) begin
        valid <= 1'b0;
      end
      if (w_commit) begin
        value <= {18'd0, w_sum};
        valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dis7seg_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dis7seg_reader
//  Function : Directed self-checking bench for dis7seg_reader. Emulates the
//             4-digit display driver scan and checks published values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dis7seg_reader;

  logic clk = 1'b0;
  logic rst;
  logic en1, en2, en3, en4;
  logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic signed [31:0] value, value_to;
  logic valid, update, error;
  logic valid_to, update_to, error_to;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  dis7seg_reader #(.SETTLE(16), .TIMEOUT(1048576)) dut (
    .clk(clk), .rst(rst),
    .en1(en1), .en2(en2), .en3(en3), .en4(en4),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g),
    .value(value), .valid(valid), .update(update), .error(error)
  );

  dis7seg_reader #(.SETTLE(16), .TIMEOUT(64)) dut_to (
    .clk(clk), .rst(rst),
    .en1(en1), .en2(en2), .en3(en3), .en4(en4),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g),
    .value(value_to), .valid(valid_to), .update(update_to), .error(error_to)
  );

  // Pulse counters for the main instance
  always @(negedge clk) begin
    if (update) upd_cnt <= upd_cnt + 1;
    if (error)  err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic drive(input logic [3:0] en_n, input logic [6:0] p);
    {en4, en3, en2, en1} = en_n;
    {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a} = p;
  endtask

  task automatic strobe(input int idx, input logic [6:0] p, input int len);
    logic [3:0] oh;
    oh = 4'b0001 << (idx - 1);
    drive(~oh, p);
    repeat (len) @(negedge clk);
  endtask

  task automatic scan(input int n, input int len);
    strobe(1, seg_of(n % 10), len);
    strobe(2, seg_of((n / 10) % 10), len);
    strobe(3, seg_of((n / 100) % 10), len);
    strobe(4, seg_of((n / 1000) % 10), len);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    drive(4'hF, 7'h00);
    repeat (3) @(negedge clk);
    check("rst_value",  value,  0);
    check("rst_valid",  valid,  0);
    check("rst_update", update, 0);
    check("rst_error",  error,  0);
    rst = 1'b0;
    @(negedge clk);

    // Scan of 1234 with exact commit latency on the thousands strobe
    strobe(1, seg_of(4), 256);
    strobe(2, seg_of(3), 256);
    strobe(3, seg_of(2), 256);
    drive(4'b0111, seg_of(1));
    repeat (19) @(negedge clk);
    check("t1_value_before", value, 0);
    check("t1_update_before", update, 0);
    @(negedge clk);
    check("t1_value", value, 1234);
    check("t1_update", update, 1);
    check("t1_valid", valid, 1);
    @(negedge clk);
    check("t1_update_single", update, 0);
    repeat (235) @(negedge clk);
    check("t1_upd_cnt", upd_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);

    // Reset in the middle of a settling strobe, then republish
    strobe(1, seg_of(4), 10);
    rst = 1'b1;
    #1;
    check("rst_mid_value", value, 0);
    check("rst_mid_valid", valid, 0);
    @(negedge clk);
    rst = 1'b0;
    scan(1234, 256);
    check("rst_again_value", value, 1234);
    check("rst_again_valid", valid, 1);
    check("rst_again_upd_cnt", upd_cnt, 2);

    // Number changes from 1234 to 0907 mid-scan
    strobe(1, seg_of(4), 256);
    strobe(2, seg_of(3), 256);
    strobe(3, seg_of(9), 256);
    strobe(4, seg_of(0), 256);
    check("chg_mixed_value", value, 934);
    scan(907, 256);
    check("chg_value", value, 907);
    check("chg_upd_cnt", upd_cnt, 4);

    // Short en2 strobe in a 5678 scan is ignored
    strobe(1, seg_of(8), 256);
    strobe(2, seg_of(7), 10);
    strobe(3, seg_of(6), 256);
    strobe(4, seg_of(5), 256);
    check("short_no_update", upd_cnt, 4);
    check("short_value_held", value, 907);
    strobe(1, seg_of(8), 256);
    strobe(2, seg_of(7), 256);
    check("short_next_value", value, 5678);
    check("short_next_upd", upd_cnt, 5);
    strobe(3, seg_of(6), 256);
    strobe(4, seg_of(5), 256);
    strobe(1, seg_of(8), 256);
    strobe(2, seg_of(7), 256);
    check("realign_upd", upd_cnt, 6);

    // Illegal pattern on the hundreds strobe
    strobe(1, seg_of(1), 256);
    strobe(2, seg_of(2), 256);
    strobe(3, 7'h77, 256);
    strobe(4, seg_of(4), 256);
    check("bad_err_cnt", err_cnt, 1);
    check("bad_no_update", upd_cnt, 6);
    check("bad_value_held", value, 5678);
    scan(4321, 256);
    check("clean_value", value, 4321);
    check("clean_upd_cnt", upd_cnt, 7);
    check("clean_err_cnt", err_cnt, 1);

    // Two enables low together
    drive(4'b1010, seg_of(1));
    repeat (100) @(negedge clk);
    check("dual_upd_cnt", upd_cnt, 7);
    check("dual_err_cnt", err_cnt, 1);
    check("dual_value", value, 4321);

    // Timeout instance: idle long since, then a fast scan and a stop
    check("to_expired_before", valid_to, 0);
    strobe(1, seg_of(4), 24);
    strobe(2, seg_of(3), 24);
    strobe(3, seg_of(2), 24);
    drive(4'b0111, seg_of(1));
    repeat (20) @(negedge clk);
    check("to_update", update_to, 1);
    check("to_value", value_to, 1234);
    check("to_valid", valid_to, 1);
    check("main_mixed_4234", value, 4234);
    drive(4'hF, 7'h00);
    repeat (60) @(negedge clk);
    check("to_valid_still", valid_to, 1);
    repeat (4) @(negedge clk);
    check("to_valid_dropped", valid_to, 0);
    check("to_value_held", value_to, 1234);
    check("main_valid_kept", valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dis7seg_reader.md
# dis7seg_reader

Samples an external multiplexed 4-digit common-cathode 7-segment display and recovers the decimal number shown on it. Consumes active-low digit enables plus active-high segment lines, exactly as produced by the team's 4-digit display driver. Settle-filters each digit strobe, decodes each segment pattern to a BCD digit, assembles complete frames and publishes a 32-bit value. Sits in a plugin next to the display driver, with its output on the signed 32-bit input-value path.

## Interface
- SETTLE, 16: synchronized cycles one enable must be stable low, with unchanged segments, before the digit is captured (range 2..255).
- TIMEOUT, 1048576: cycles without any digit capture before `valid` drops (range 16..2^24).
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en1..en4  in  1 each  digit enables, active low; en1 = ones, en4 = thousands.
- seg_a..seg_g  in  1 each  segment lines, active high; pattern p = {g,f,e,d,c,b,a}.
- value  out  32 (signed)  last complete decoded number, 0..9999, zero-extended.
- valid  out  1  high while frames keep arriving within TIMEOUT.
- update  out  1  one-cycle pulse when `value` is (re)written.
- error  out  1  one-cycle pulse when a captured pattern is not a decimal digit.

## Operation
- All 11 inputs pass through a 2-flop synchronizer; all logic below sees synchronized signals only.
- Strobe FSM, states IDLE, SETTLE, HELD:
  - IDLE: exactly one enable low -> SETTLE; latch the digit index and pattern; clear settle counter.
  - Zero enables low, or two or more low -> IDLE.
  - SETTLE: same single enable low and pattern equal to the latched one -> increment counter.
  - SETTLE, counter reaches SETTLE-1 -> capture the digit, go to HELD.
  - SETTLE, enable set or pattern changes -> restart SETTLE with the new values, or go to IDLE if the enable condition fails.
  - HELD: hold until the enable set changes; then same evaluation as IDLE. One capture per strobe.
- Decode table (p in hex) -> digit: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
  - Any other pattern, including hex A-F codes and 00: pulse `error`, clear that digit's mask bit, no digit store.
- Frame assembly: digit registers d1..d4 plus a 4-bit captured mask.
  - A valid capture stores the digit and sets its mask bit; recapturing an already-set digit overwrites it.
  - Mask becomes 1111 -> commit cycle: value <= d4*1000 + d3*100 + d2*10 + d1 (14-bit unsigned result, zero-extended to 32 bits). Also valid <= 1, update pulse, mask cleared.
- Timeout: counter cleared on every valid capture; on reaching TIMEOUT-1, valid <= 0.
  - `value` is held and the mask is cleared.
- Reset mid-operation: FSM -> IDLE; counters, mask and digit registers cleared; synchronizers cleared.

## Timing
- Reset values: value=0, valid=0, update=0, error=0, FSM IDLE, mask 0000.
- Pin-to-synchronized latency: 2 cycles.
- Capture occurs SETTLE cycles after the first synchronized cycle of a stable strobe. A strobe shorter than SETTLE synchronized cycles is ignored.
- `error` pulses in the capture cycle +1.
- Valid digit stored in the capture cycle +1.
- `value`/`valid`/`update` change one cycle after the completing digit is stored, i.e. capture cycle +2.
- Capture and timeout expiry in the same cycle: capture wins; timeout counter cleared; valid unchanged.
- Commit and invalid capture never coincide; only one capture can occur per cycle.

## Test plan
- Drive the driver's scan for 1234 (strobes 256 cycles each, en1..en4 in order), SETTLE=16 -> after the 4th strobe, update pulses once; value=1234; valid=1; error never asserted.
- Change the scanned number from 1234 to 0907 mid-scan -> first full frame after the change yields value=907. At most one intermediate mixed frame is allowed, and it must contain only digits actually displayed.
- Strobe en2 low for only 10 cycles (SETTLE=16) among otherwise normal strobes for 5678 -> ignored; next complete frame gives 5678.
- Present pattern 0x77 ("A") on the en3 strobe -> error pulses once; no update for that scan. The next clean scan of 4321 gives value=4321.
- Drive en1 and en3 low together for 100 cycles -> no capture, no error. Then stop all strobes with TIMEOUT=64 -> valid falls 64 cycles after the last capture; value holds.
- Assert rst mid-SETTLE after value=1234 -> value=0, valid=0 immediately. The first complete frame after release republishes 1234.
